stream_switch_splitter_regs: RTL and testbench

AXI-Lite register slave for the stream-switch splitter, attached to the splitter port of the box address map, which delivers 12-bit, zero-based offsets. It holds the splitter's configuration (enable, default egress port, header match value and mask) and keeps saturating 32-bit per-port packet counters, driven by single-cycle event pulses from the splitter datapath. Each direction allows one outstanding transaction; there are no byte strobes, so every write is a full 32-bit word.

---
 rtl/stream_switch_splitter_regs_if.sv | 30 +++
 rtl/stream_switch_splitter_regs.sv | 196 +++++++++++++++++++
 tb/tb_stream_switch_splitter_regs.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_switch_splitter_regs_if.sv
// AXI-Lite bundle for the stream-switch splitter register slave.
// Handshake: a beat moves on every rising clock edge where valid && ready; the sender holds payload stable while valid is high.
interface stream_switch_splitter_regs_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/stream_switch_splitter_regs.sv
// AXI-Lite register slave for the stream-switch splitter: configuration registers
// plus saturating per-port packet counters fed by single-cycle event pulses.
module stream_switch_splitter_regs #(
   parameter logic [31:0] ID_VALUE           = 32'h53504C54,
   parameter logic [1:0]  RESET_DEFAULT_PORT = 2'd0
) (
   input  logic                               aclk,
   input  logic                               areset,
   stream_switch_splitter_regs_if.slave       s_axil,
   input  logic                               stat_pkt_port0,
   input  logic                               stat_pkt_port1,
   input  logic                               stat_pkt_drop,
   output logic                               cfg_enable,
   output logic [1:0]                         cfg_default_port,
   output logic [31:0]                        cfg_match_value,
   output logic [31:0]                        cfg_match_mask,
   output logic                               dbg_w_state,
   output logic                               dbg_r_state
);
   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [0:0]  w_state;
   logic [0:0]  r_state;
   logic        aw_done;
   logic        w_done;
   logic [9:0]  aw_idx_q;
   logic [31:0] wdata_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic [31:0] cnt_port0;
   logic [31:0] cnt_port1;
   logic [31:0] cnt_drop;

   logic        aw_hs;
   logic        w_hs;
   logic        ar_hs;
   logic        do_write;
   logic        wr_ok;
   logic        cnt_clear;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data;
   logic [31:0] cnt_port0_nxt;
   logic [31:0] cnt_port1_nxt;
   logic [31:0] cnt_drop_nxt;
   logic [31:0] rd_val;
   logic        rd_ok;
   logic        unused_addr_bits;

   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic p);
      sat_inc = (p && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
   endfunction

   assign s_axil.awready = !areset && (w_state == W_IDLE) && !aw_done;
   assign s_axil.wready  = !areset && (w_state == W_IDLE) && !w_done;
   assign s_axil.arready = !areset && (r_state == R_IDLE);
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = rresp_q;
   assign dbg_w_state    = w_state;
   assign dbg_r_state    = r_state;
   assign unused_addr_bits = ^{s_axil.awaddr[31:12], s_axil.awaddr[1:0],
                               s_axil.araddr[31:12], s_axil.araddr[1:0]};

   assign aw_hs = s_axil.awvalid && s_axil.awready;
   assign w_hs  = s_axil.wvalid && s_axil.wready;
   assign ar_hs = s_axil.arvalid && s_axil.arready;

   // A beat captured in an earlier cycle is replayed from its holding register.
   always_comb begin
      wr_idx    = aw_done ? aw_idx_q : s_axil.awaddr[11:2];
      wr_data   = w_done ? wdata_q : s_axil.wdata;
      do_write  = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
      wr_ok     = (wr_idx == 10'd1) || (wr_idx == 10'd2) || (wr_idx == 10'd3) || (wr_idx == 10'd4);
      cnt_clear = do_write && (wr_idx == 10'd1) && wr_data[1];
   end

   assign cnt_port0_nxt = sat_inc(cnt_port0, stat_pkt_port0);
   assign cnt_port1_nxt = sat_inc(cnt_port1, stat_pkt_port1);
   assign cnt_drop_nxt  = sat_inc(cnt_drop, stat_pkt_drop);

   // Counter reads include a pulse landing in the handshake cycle, but not a same-cycle clear.
   always_comb begin
      rd_val = 32'd0;
      rd_ok  = 1'b1;
      case (s_axil.araddr[11:2])
         10'd0:   rd_val = ID_VALUE;
         10'd1:   rd_val = {31'd0, cfg_enable};
         10'd2:   rd_val = {30'd0, cfg_default_port};
         10'd3:   rd_val = cfg_match_value;
         10'd4:   rd_val = cfg_match_mask;
         10'd8:   rd_val = cnt_port0_nxt;
         10'd9:   rd_val = cnt_port1_nxt;
         10'd10:  rd_val = cnt_drop_nxt;
         default: rd_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state          <= W_IDLE;
         aw_done          <= 1'b0;
         w_done           <= 1'b0;
         aw_idx_q         <= 10'd0;
         wdata_q          <= 32'd0;
         bvalid_q         <= 1'b0;
         bresp_q          <= RESP_OKAY;
         cfg_enable       <= 1'b0;
         cfg_default_port <= RESET_DEFAULT_PORT;
         cfg_match_value  <= 32'd0;
         cfg_match_mask   <= 32'd0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (do_write) begin
                  case (wr_idx)
                     10'd1:   cfg_enable       <= wr_data[0];
                     10'd2:   cfg_default_port <= wr_data[1:0];
                     10'd3:   cfg_match_value  <= wr_data;
                     10'd4:   cfg_match_mask   <= wr_data;
                     default: ;
                  endcase
                  bvalid_q <= 1'b1;
                  bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  w_state  <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_done  <= 1'b1;
                     aw_idx_q <= s_axil.awaddr[11:2];
                  end
                  if (w_hs) begin
                     w_done  <= 1'b1;
                     wdata_q <= s_axil.wdata;
                  end
               end
            end
            default: begin
               if (s_axil.bready) begin
                  bvalid_q <= 1'b0;
                  w_state  <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         rresp_q  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q  <= rd_val;
                  rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                  rvalid_q <= 1'b1;
                  r_state  <= R_DATA;
               end
            end
            default: begin
               if (s_axil.rready) begin
                  rvalid_q <= 1'b0;
                  r_state  <= R_IDLE;
               end
            end
         endcase
      end
   end

   // Clear beats any pulse arriving in the same cycle.
   always_ff @(posedge aclk) begin
      if (areset || cnt_clear) begin
         cnt_port0 <= 32'd0;
         cnt_port1 <= 32'd0;
         cnt_drop  <= 32'd0;
      end else begin
         cnt_port0 <= cnt_port0_nxt;
         cnt_port1 <= cnt_port1_nxt;
         cnt_drop  <= cnt_drop_nxt;
      end
   end
endmodule

// File: tb/tb_stream_switch_splitter_regs.sv
// Directed bench for stream_switch_splitter_regs: inputs change and outputs are sampled on the falling edge.
module tb_stream_switch_splitter_regs;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        stat_pkt_port0 = 1'b0;
   logic        stat_pkt_port1 = 1'b0;
   logic        stat_pkt_drop = 1'b0;
   logic        cfg_enable;
   logic [1:0]  cfg_default_port;
   logic [31:0] cfg_match_value;
   logic [31:0] cfg_match_mask;
   logic        dbg_w_state;
   logic        dbg_r_state;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] rd;
   logic [1:0]  rsp;

   always #5 aclk = ~aclk;

   stream_switch_splitter_regs_if axil ();

   stream_switch_splitter_regs dut (
      .aclk             (aclk),
      .areset           (areset),
      .s_axil           (axil),
      .stat_pkt_port0   (stat_pkt_port0),
      .stat_pkt_port1   (stat_pkt_port1),
      .stat_pkt_drop    (stat_pkt_drop),
      .cfg_enable       (cfg_enable),
      .cfg_default_port (cfg_default_port),
      .cfg_match_value  (cfg_match_value),
      .cfg_match_mask   (cfg_match_mask),
      .dbg_w_state      (dbg_w_state),
      .dbg_r_state      (dbg_r_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
      int t;
      logic aw_fire;
      logic w_fire;
      @(negedge aclk);
      axil.awvalid = 1'b1; axil.awaddr = addr;
      axil.wvalid  = 1'b1; axil.wdata  = data;
      t = 0;
      while ((axil.awvalid || axil.wvalid) && t < 20) begin
         aw_fire = axil.awvalid && axil.awready;
         w_fire  = axil.wvalid && axil.wready;
         @(negedge aclk);
         t++;
         if (aw_fire) axil.awvalid = 1'b0;
         if (w_fire)  axil.wvalid  = 1'b0;
      end
      check("wr_handshake_done", {31'd0, axil.awvalid || axil.wvalid}, 32'd0);
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      check("bvalid_latency", {31'd0, axil.bvalid}, 32'd1);
      resp = axil.bresp;
      axil.bready = 1'b1;
      @(negedge aclk);
      axil.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      @(negedge aclk);
      axil.arvalid = 1'b1; axil.araddr = addr;
      @(negedge aclk);
      axil.arvalid = 1'b0;
      check("rvalid_latency", {31'd0, axil.rvalid}, 32'd1);
      data = axil.rdata;
      resp = axil.rresp;
      axil.rready = 1'b1;
      @(negedge aclk);
      axil.rready = 1'b0;
      check("rvalid_drop", {31'd0, axil.rvalid}, 32'd0);
   endtask

   initial begin
      axil.awvalid = 1'b0; axil.awaddr = 32'd0; axil.wvalid = 1'b0; axil.wdata = 32'd0;
      axil.bready = 1'b0; axil.arvalid = 1'b0; axil.araddr = 32'd0; axil.rready = 1'b0;

      // Reset state
      repeat (3) @(negedge aclk);
      check("rst_awready", {31'd0, axil.awready}, 32'd0);
      check("rst_wready", {31'd0, axil.wready}, 32'd0);
      check("rst_arready", {31'd0, axil.arready}, 32'd0);
      check("rst_bvalid", {31'd0, axil.bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, axil.rvalid}, 32'd0);
      check("rst_rdata", axil.rdata, 32'd0);
      check("rst_enable", {31'd0, cfg_enable}, 32'd0);
      check("rst_port", {30'd0, cfg_default_port}, 32'd0);
      check("rst_match", cfg_match_value, 32'd0);
      check("rst_mask", cfg_match_mask, 32'd0);
      areset = 1'b0;
      #1;
      check("post_rst_awready", {31'd0, axil.awready}, 32'd1);
      check("post_rst_arready", {31'd0, axil.arready}, 32'd1);

      // ID register, including an aliased address with upper bits set
      axi_read(32'h0000_0000, rd, rsp);
      check("id_data", rd, 32'h53504C54);
      check("id_resp", {30'd0, rsp}, 32'd0);
      axi_read(32'hABCD_1000, rd, rsp);
      check("id_alias_data", rd, 32'h53504C54);

      // W arrives three cycles before AW
      @(negedge aclk);
      axil.wvalid = 1'b1; axil.wdata = 32'h1;
      @(negedge aclk);
      axil.wvalid = 1'b0;
      check("w_first_wready", {31'd0, axil.wready}, 32'd0);
      check("w_first_no_bvalid", {31'd0, axil.bvalid}, 32'd0);
      @(negedge aclk);
      @(negedge aclk);
      axil.awvalid = 1'b1; axil.awaddr = 32'h004;
      @(negedge aclk);
      axil.awvalid = 1'b0;
      check("w_first_bvalid", {31'd0, axil.bvalid}, 32'd1);
      check("w_first_enable", {31'd0, cfg_enable}, 32'd1);
      check("w_first_dbg_state", {31'd0, dbg_w_state}, 32'd1);
      axil.bready = 1'b1;
      @(negedge aclk);
      axil.bready = 1'b0;
      axi_read(32'h004, rd, rsp);
      check("ctrl_read", rd, 32'h1);

      // DEFAULT_PORT masking, read-only and unmapped offsets
      axi_write(32'h008, 32'hFFFF_FFFF, rsp);
      check("port_bresp", {30'd0, rsp}, 32'd0);
      check("port_cfg", {30'd0, cfg_default_port}, 32'd3);
      axi_read(32'h008, rd, rsp);
      check("port_read", rd, 32'h3);
      axi_write(32'h020, 32'h1234_5678, rsp);
      check("ro_bresp", {30'd0, rsp}, 32'd2);
      axi_read(32'h020, rd, rsp);
      check("ro_cnt_unchanged", rd, 32'd0);
      axi_read(32'h100, rd, rsp);
      check("unmapped_rresp", {30'd0, rsp}, 32'd2);
      check("unmapped_rdata", rd, 32'd0);
      axi_write(32'h014, 32'h5, rsp);
      check("unmapped_bresp", {30'd0, rsp}, 32'd2);

      axi_write(32'h00C, 32'hA5A5_0F0F, rsp);
      check("match_cfg", cfg_match_value, 32'hA5A5_0F0F);
      axi_write(32'h010, 32'hFFFF_0000, rsp);
      check("mask_cfg", cfg_match_mask, 32'hFFFF_0000);

      // Pulse in the AR handshake cycle is included in the read
      @(negedge aclk);
      axil.arvalid = 1'b1; axil.araddr = 32'h020; stat_pkt_port0 = 1'b1;
      @(negedge aclk);
      axil.arvalid = 1'b0; stat_pkt_port0 = 1'b0;
      check("cnt0_same_cycle", axil.rdata, 32'd1);
      axil.rready = 1'b1;
      @(negedge aclk);
      axil.rready = 1'b0;

      // Clear collides with the fifth port1 pulse
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk); stat_pkt_port1 = 1'b1;
         @(negedge aclk); stat_pkt_port1 = 1'b0;
      end
      axi_read(32'h024, rd, rsp);
      check("cnt1_four", rd, 32'd4);
      @(negedge aclk);
      axil.awvalid = 1'b1; axil.awaddr = 32'h004; axil.wvalid = 1'b1; axil.wdata = 32'h3;
      stat_pkt_port1 = 1'b1;
      @(negedge aclk);
      axil.awvalid = 1'b0; axil.wvalid = 1'b0; stat_pkt_port1 = 1'b0;
      check("clear_bvalid", {31'd0, axil.bvalid}, 32'd1);
      check("clear_bresp", {30'd0, axil.bresp}, 32'd0);
      check("clear_enable_kept", {31'd0, cfg_enable}, 32'd1);
      axil.bready = 1'b1;
      @(negedge aclk);
      axil.bready = 1'b0;
      axi_read(32'h024, rd, rsp);
      check("cnt1_cleared", rd, 32'd0);
      axi_read(32'h020, rd, rsp);
      check("cnt0_cleared", rd, 32'd0);
      axi_read(32'h004, rd, rsp);
      check("ctrl_clear_reads0", rd, 32'h1);
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk); stat_pkt_port1 = 1'b1;
         @(negedge aclk); stat_pkt_port1 = 1'b0;
      end
      axi_read(32'h024, rd, rsp);
      check("cnt1_two", rd, 32'd2);

      // Drop counter saturation from a preloaded value
      @(negedge aclk);
      force dut.cnt_drop = 32'hFFFF_FFFD;
      #1;
      release dut.cnt_drop;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk); stat_pkt_drop = 1'b1;
         @(negedge aclk); stat_pkt_drop = 1'b0;
      end
      axi_read(32'h028, rd, rsp);
      check("drop_saturated", rd, 32'hFFFF_FFFF);

      // Read stalled on rready while a write proceeds
      @(negedge aclk);
      axil.arvalid = 1'b1; axil.araddr = 32'h00C;
      @(negedge aclk);
      axil.arvalid = 1'b0;
      check("stall_rvalid", {31'd0, axil.rvalid}, 32'd1);
      check("stall_rdata_first", axil.rdata, 32'hA5A5_0F0F);
      axi_write(32'h00C, 32'h1234_5678, rsp);
      check("stall_wr_bresp", {30'd0, rsp}, 32'd0);
      repeat (6) @(negedge aclk);
      check("stall_rvalid_held", {31'd0, axil.rvalid}, 32'd1);
      check("stall_rdata_held", axil.rdata, 32'hA5A5_0F0F);
      check("stall_arready_low", {31'd0, axil.arready}, 32'd0);
      check("stall_cfg_updated", cfg_match_value, 32'h1234_5678);
      axil.rready = 1'b1;
      @(negedge aclk);
      axil.rready = 1'b0;
      axi_read(32'h00C, rd, rsp);
      check("match_readback", rd, 32'h1234_5678);

      // Reset while bvalid is pending
      @(negedge aclk);
      axil.awvalid = 1'b1; axil.awaddr = 32'h010; axil.wvalid = 1'b1; axil.wdata = 32'h0000_00FF;
      @(negedge aclk);
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      check("pre_rst_bvalid", {31'd0, axil.bvalid}, 32'd1);
      areset = 1'b1;
      @(negedge aclk);
      check("mid_rst_bvalid", {31'd0, axil.bvalid}, 32'd0);
      check("mid_rst_enable", {31'd0, cfg_enable}, 32'd0);
      check("mid_rst_port", {30'd0, cfg_default_port}, 32'd0);
      check("mid_rst_match", cfg_match_value, 32'd0);
      check("mid_rst_mask", cfg_match_mask, 32'd0);
      check("mid_rst_awready", {31'd0, axil.awready}, 32'd0);
      areset = 1'b0;
      #1;
      check("after_rst_awready", {31'd0, axil.awready}, 32'd1);
      axi_read(32'h024, rd, rsp);
      check("after_rst_cnt1", rd, 32'd0);

      repeat (2) @(negedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
